seg7_capture: RTL



---
 rtl/seg7_pkg.sv | 28 ++
 rtl/seg7_decode.sv | 38 +++
 rtl/seg7_capture.sv | 112 +++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment capture block.
// Segment patterns are active-low, bit6 = a ... bit0 = g.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0001100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    COLLECT = 1'b0,
    PRESENT = 1'b1
  } frame_state_t;

endpackage

// File: rtl/seg7_decode.sv
// Pattern to hex decoder: pat (7b, active-low a..g) in;
// val (4b), blank (all segments off), err (unknown) out.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pat,
  output logic [3:0] val,
  output logic       blank,
  output logic       err
);

  always_comb begin
    val   = 4'h0;
    blank = 1'b0;
    err   = 1'b0;
    unique case (pat)
      SEG_0:     val = 4'h0;
      SEG_1:     val = 4'h1;
      SEG_2:     val = 4'h2;
      SEG_3:     val = 4'h3;
      SEG_4:     val = 4'h4;
      SEG_5:     val = 4'h5;
      SEG_6:     val = 4'h6;
      SEG_7:     val = 4'h7;
      SEG_8:     val = 4'h8;
      SEG_9:     val = 4'h9;
      SEG_A:     val = 4'hA;
      SEG_B:     val = 4'hB;
      SEG_C:     val = 4'hC;
      SEG_D:     val = 4'hD;
      SEG_E:     val = 4'hE;
      SEG_F:     val = 4'hF;
      SEG_BLANK: blank = 1'b1;
      default:   err = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_capture.sv
// Recovers hex digits from a multiplexed active-low 7-seg bus.
// In: clk, rst, seg_in, an_in, frame_ready. Out: frame_* bundle, an_err.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int NDIG          = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        seg_in,
  input  logic [NDIG-1:0]   an_in,
  input  logic              frame_ready,
  output logic              frame_valid,
  output logic [4*NDIG-1:0] frame_digits,
  output logic [NDIG-1:0]   frame_blank,
  output logic [NDIG-1:0]   frame_err,
  output logic              an_err
);

  localparam logic [7:0] CMAX = 8'(STABLE_CYCLES);
  localparam logic [7:0] CACC = 8'(STABLE_CYCLES - 1);
  localparam logic [NDIG-1:0] ONE  = 1;
  localparam logic [NDIG-1:0] ALL  = '1;

  logic [6:0]        s_seg, p_seg;
  logic [NDIG-1:0]   s_an, p_an;
  logic [7:0]        cnt, cnt_nx;
  logic [4*NDIG-1:0] live_dig;
  logic [NDIG-1:0]   live_blank, live_err;
  logic [NDIG-1:0]   seen, low, set_mask;
  logic              same, accept, multi, one;
  logic              snap;
  logic [3:0]        d_val;
  logic              d_blank, d_err;
  frame_state_t      state;

  seg7_decode u_dec (
    .pat   (s_seg),
    .val   (d_val),
    .blank (d_blank),
    .err   (d_err)
  );

  assign same   = ({s_seg, s_an} == {p_seg, p_an});
  assign cnt_nx = !same ? 8'd0 :
                  (cnt == CMAX) ? CMAX : cnt + 8'd1;
  // Saturation keeps cnt past CACC, so this fires once per run.
  assign accept = same && (cnt_nx == CACC);

  assign low   = ~s_an;
  assign multi = |(low & (low - ONE));
  assign one   = (|low) && !multi;

  assign set_mask = (accept && one) ? low : '0;
  assign snap     = (state == COLLECT) && (seen == ALL);

  always_ff @(posedge clk) begin
    if (rst) begin
      s_seg        <= SEG_BLANK;
      s_an         <= ALL;
      p_seg        <= SEG_BLANK;
      p_an         <= ALL;
      cnt          <= 8'd0;
      seen         <= '0;
      live_dig     <= '0;
      live_blank   <= '0;
      live_err     <= '0;
      frame_valid  <= 1'b0;
      frame_digits <= '0;
      frame_blank  <= '0;
      frame_err    <= '0;
      an_err       <= 1'b0;
      state        <= COLLECT;
    end else begin
      s_seg  <= seg_in;
      s_an   <= an_in;
      p_seg  <= s_seg;
      p_an   <= s_an;
      cnt    <= cnt_nx;
      an_err <= accept && multi;
      // A new accept survives the snapshot clear.
      seen   <= (snap ? '0 : seen) | set_mask;
      for (int i = 0; i < NDIG; i++) begin
        if (set_mask[i]) begin
          live_dig[4*i +: 4] <= d_val;
          live_blank[i]      <= d_blank;
          live_err[i]        <= d_err;
        end
      end
      unique case (state)
        COLLECT: begin
          if (snap) begin
            frame_digits <= live_dig;
            frame_blank  <= live_blank;
            frame_err    <= live_err;
            frame_valid  <= 1'b1;
            state        <= PRESENT;
          end
        end
        PRESENT: begin
          if (frame_valid && frame_ready) begin
            frame_valid <= 1'b0;
            state       <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule
